// File: rtl/stream_multiply.sv
// Streaming signed fixed-point multiplier: x*y (or x*x in square mode), dequantised by 2^QUANT_BITS,
// credit-controlled output buffer. Define MULT_SATURATE_EN to clamp results and expose sat_flag.
module stream_multiply #(
    parameter int DATA_SIZE   = 32,
    parameter int QUANT_BITS  = 10,
    parameter int PIPE_STAGES = 2,
    parameter int OBUF_DEPTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 square_mode,
    input  logic [DATA_SIZE-1:0] x_dout,
    input  logic                 x_empty,
    output logic                 x_rd_en,
    input  logic [DATA_SIZE-1:0] y_dout,
    input  logic                 y_empty,
    output logic                 y_rd_en,
    output logic [DATA_SIZE-1:0] z_din,
    output logic                 z_wr_en,
    input  logic                 z_full,
`ifdef MULT_SATURATE_EN
    output logic                 sat_flag,
`endif
    output logic                 busy
);

    localparam int PW    = 2 * DATA_SIZE;
    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

    localparam logic [CNT_W:0]  CREDIT_LIMIT = (CNT_W + 1)'(OBUF_DEPTH);
    localparam logic [PW-1:0]   ROUND_BIAS   = {{(PW - QUANT_BITS){1'b0}}, {QUANT_BITS{1'b1}}};
`ifdef MULT_SATURATE_EN
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_SIZE + 1){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_SIZE + 1){1'b1}}, {(DATA_SIZE - 1){1'b0}}};
`endif

    logic                   issue;
    logic [CNT_W:0]         credit_used;
    logic [DATA_SIZE-1:0]   op_b;
    logic signed [PW-1:0]   op_a_ext;
    logic signed [PW-1:0]   op_b_ext;
    logic signed [PW-1:0]   stage_in [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [DATA_SIZE-1:0]   res_q;
`ifdef MULT_SATURATE_EN
    logic                   res_clamp;
    logic                   sat_q;
    logic                   sat_d;
`endif

    logic [DATA_SIZE-1:0]   obuf_mem [OBUF_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_d;
    logic [CNT_W-1:0]       obuf_count_q;
    logic [CNT_W-1:0]       obuf_count_d;
    logic [CNT_W-1:0]       inflight_q;
    logic [CNT_W-1:0]       inflight_d;
    logic                   pipe_exit;
    logic                   obuf_wr;
    logic                   obuf_rd;

    // Every issued sample holds a credit until it leaves the buffer, so the pipeline never stalls.
    assign credit_used = {1'b0, inflight_q} + {1'b0, obuf_count_q};
    assign issue       = reset && !x_empty && (square_mode || !y_empty) && (credit_used < CREDIT_LIMIT);
    assign x_rd_en     = issue;
    assign y_rd_en     = issue && !square_mode;

    assign op_b        = square_mode ? x_dout : y_dout;
    assign op_a_ext    = {{DATA_SIZE{x_dout[DATA_SIZE-1]}}, x_dout};
    assign op_b_ext    = {{DATA_SIZE{op_b[DATA_SIZE-1]}}, op_b};
    assign stage_in[0] = op_a_ext * op_b_ext;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_valid_first
                assign valid_d[gi] = issue;
            end else begin : g_valid_next
                assign valid_d[gi] = valid_q[gi-1];
            end

            if (gi == PIPE_STAGES - 1) begin : g_last
                logic [PW-1:0]        bias_sel;
                logic signed [PW-1:0] adj;
                logic [DATA_SIZE-1:0] res_d;
`ifdef MULT_SATURATE_EN
                logic signed [PW-1:0] wide;
`endif
                // Biasing negatives by 2^Q-1 makes the arithmetic shift truncate toward zero.
                always_comb begin
                    bias_sel = stage_in[gi][PW-1] ? ROUND_BIAS : '0;
                    adj      = stage_in[gi] + $signed(bias_sel);
`ifdef MULT_SATURATE_EN
                    wide      = adj >>> QUANT_BITS;
                    res_clamp = 1'b0;
                    res_d     = wide[DATA_SIZE-1:0];
                    if (wide > SAT_MAX) begin
                        res_clamp = 1'b1;
                        res_d     = SAT_MAX[DATA_SIZE-1:0];
                    end else if (wide < SAT_MIN) begin
                        res_clamp = 1'b1;
                        res_d     = SAT_MIN[DATA_SIZE-1:0];
                    end
`else
                    res_d    = DATA_SIZE'(adj >>> QUANT_BITS);
`endif
                end

                always_ff @(posedge clock) begin
                    if (valid_d[gi]) begin
                        res_q <= res_d;
                    end
                end
            end else begin : g_mid
                logic signed [PW-1:0] prod_q;

                always_ff @(posedge clock) begin
                    if (valid_d[gi]) begin
                        prod_q <= stage_in[gi];
                    end
                end
                assign stage_in[gi+1] = prod_q;
            end
        end
    endgenerate

    assign pipe_exit = valid_q[PIPE_STAGES-1];
    assign obuf_wr   = pipe_exit;
    assign obuf_rd   = (obuf_count_q != '0) && !z_full;

    always_ff @(posedge clock) begin
        if (obuf_wr) begin
            obuf_mem[wr_ptr_q] <= res_q;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        obuf_count_d = obuf_count_q;
        inflight_d   = inflight_q;
        if (obuf_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (obuf_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({obuf_wr, obuf_rd})
            2'b10:   obuf_count_d = obuf_count_q + 1'b1;
            2'b01:   obuf_count_d = obuf_count_q - 1'b1;
            default: obuf_count_d = obuf_count_q;
        endcase
        case ({issue, pipe_exit})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

`ifdef MULT_SATURATE_EN
    assign sat_d    = sat_q || (valid_d[PIPE_STAGES-1] && res_clamp);
    assign sat_flag = sat_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            obuf_count_q <= '0;
            inflight_q   <= '0;
`ifdef MULT_SATURATE_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            obuf_count_q <= obuf_count_d;
            inflight_q   <= inflight_d;
`ifdef MULT_SATURATE_EN
            sat_q        <= sat_d;
`endif
        end
    end

    assign z_wr_en = obuf_rd;
    assign z_din   = (obuf_count_q != '0) ? obuf_mem[rd_ptr_q] : '0;
    assign busy    = (inflight_q != '0) || (obuf_count_q != '0);

endmodule

// File: tb/tb_stream_multiply.sv
// Directed + randomized bench for stream_multiply with queue-based upstream FIFOs and an
// arithmetic reference model (truncating division) feeding an expected-result queue.
module tb_stream_multiply;
    localparam int DW    = 32;
    localparam int QB    = 10;
    localparam int PIPE  = 2;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          square_mode = 1'b0;
    logic [DW-1:0] x_dout = '0;
    logic [DW-1:0] y_dout = '0;
    logic          x_empty = 1'b1;
    logic          y_empty = 1'b1;
    logic          z_full = 1'b0;
    logic          x_rd_en;
    logic          y_rd_en;
    logic          z_wr_en;
    logic          busy;
    logic [DW-1:0] z_din;
`ifdef MULT_SATURATE_EN
    logic          sat_flag;
`endif

    always #5 clock = ~clock;

    stream_multiply #(
        .DATA_SIZE(DW),
        .QUANT_BITS(QB),
        .PIPE_STAGES(PIPE),
        .OBUF_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .square_mode(square_mode),
        .x_dout(x_dout),
        .x_empty(x_empty),
        .x_rd_en(x_rd_en),
        .y_dout(y_dout),
        .y_empty(y_empty),
        .y_rd_en(y_rd_en),
        .z_din(z_din),
        .z_wr_en(z_wr_en),
        .z_full(z_full),
`ifdef MULT_SATURATE_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] x_fifo [$];
    logic [DW-1:0] y_fifo [$];
    logic [DW-1:0] exp_q  [$];
    int            cyc = 0;
    int            issues, pushes, first_issue_cyc, first_push_cyc, last_push_cyc, max_gap;
    bit            full_rand = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: exact product, integer division truncates toward zero, then wrap or clamp.
    function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint     p;
        longint     q;
        logic [63:0] qbits;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p / (longint'(1) << QB);
`ifdef MULT_SATURATE_EN
        if (q > (longint'(1) << (DW - 1)) - 1) q = (longint'(1) << (DW - 1)) - 1;
        else if (q < -(longint'(1) << (DW - 1))) q = -(longint'(1) << (DW - 1));
`endif
        qbits = q;
        return qbits[DW-1:0];
    endfunction

    task automatic drive_fifos();
        x_empty = (x_fifo.size() == 0);
        y_empty = (y_fifo.size() == 0);
        x_dout  = x_empty ? '0 : x_fifo[0];
        y_dout  = y_empty ? '0 : y_fifo[0];
    endtask

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] e);
        x_fifo.push_back(a);
        if (!square_mode) y_fifo.push_back(b);
        exp_q.push_back(e);
        drive_fifos();
    endtask

    task automatic clear_stats();
        issues = 0; pushes = 0;
        first_issue_cyc = -1; first_push_cyc = -1; last_push_cyc = -1; max_gap = 0;
    endtask

    logic [DW-1:0] rand_val;
    task automatic gen_val();
        if ($urandom_range(0, 1) == 1) rand_val = $urandom();
        else rand_val = DW'(int'($urandom_range(0, 131071)) - 65536);
    endtask

    // One clock: sample on the falling edge, update FIFO models just after the rising edge.
    task automatic step();
        logic          xr, yr;
        logic [DW-1:0] e;
        @(negedge clock);
        cyc++;
        xr = x_rd_en;
        yr = y_rd_en;
        chk("x_rd_guard", xr & x_empty, 0);
        chk("y_rd_guard", yr & y_empty, 0);
        chk("y_rd_pairing", yr, xr & ~square_mode);
        if (xr) begin
            issues++;
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
        end
        if (z_wr_en) begin
            pushes++;
            $display("cyc=%0d push z_din=0x%08h", cyc, z_din);
            if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("z_din", z_din, e);
            end
            if (first_push_cyc < 0) first_push_cyc = cyc;
            if (last_push_cyc >= 0 && cyc - last_push_cyc > max_gap) max_gap = cyc - last_push_cyc;
            last_push_cyc = cyc;
        end
        @(posedge clock);
        #1;
        if (xr && x_fifo.size() != 0) void'(x_fifo.pop_front());
        if (yr && y_fifo.size() != 0) void'(y_fifo.pop_front());
        if (full_rand) z_full = ($urandom_range(0, 2) == 0);
        drive_fifos();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        // Reset: a pending pair must not be popped while reset is held.
        clear_stats();
        push_pair(32'h400, 32'h800, 32'h800);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_x_rd_en", x_rd_en, 0);
        chk("rst_y_rd_en", y_rd_en, 0);
        chk("rst_z_wr_en", z_wr_en, 0);
        chk("rst_z_din", z_din, 0);
        chk("rst_busy", busy, 0);
`ifdef MULT_SATURATE_EN
        chk("rst_sat_flag", sat_flag, 0);
`endif
        reset = 1'b1;

        // x*y with latency check
        drain(50);
        chk("s1_latency", 64'(first_push_cyc - first_issue_cyc), PIPE + 1);
        chk("s1_issues", issues, 1);

        // Square mode: y FIFO left untouched
        clear_stats();
        square_mode = 1'b1;
        push_pair(32'h600, 32'h0, 32'h900);
        y_fifo.push_back(32'h1234);
        drive_fifos();
        drain(50);
        chk("s2_y_untouched", 64'(y_fifo.size()), 1);
        y_fifo.delete();
        square_mode = 1'b0;
        drive_fifos();

        // Truncation toward zero
        clear_stats();
        push_pair(32'hFFFFFFFF, 32'h1, 32'h0);
        push_pair(32'hFFFFF800, 32'h600, 32'hFFFFF400);
        drain(50);
        chk("s3_pushes", pushes, 2);

        // Back-pressure: 40 pairs, z_full high for 50 cycles
        clear_stats();
        z_full = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] a, b;
            a = DW'(32'h100 + i * 32'h40);
            b = DW'(32'h400 + i * 32'h10);
            push_pair(a, b, ref_mul(a, b));
        end
        repeat (50) step();
        chk("s4_issues_held", issues, DEPTH);
        chk("s4_no_push_while_full", pushes, 0);
        chk("s4_busy_held", busy, 1);
        z_full = 1'b0;
        drain(300);
        chk("s4_pushes", pushes, 40);
        chk("s4_max_gap", max_gap, 1);
        chk("s4_busy_fall", 64'(cyc - last_push_cyc), 0);
        chk("s4_busy_low", busy, 0);

        // Starvation: 5 x, 3 y
        clear_stats();
        for (int i = 0; i < 3; i++) push_pair(DW'(32'h400 * (i + 1)), 32'h400, DW'(32'h400 * (i + 1)));
        x_fifo.push_back(32'h111);
        x_fifo.push_back(32'h222);
        drive_fifos();
        drain(50);
        repeat (5) step();
        chk("s5_issues", issues, 3);
        chk("s5_x_left", 64'(x_fifo.size()), 2);
        chk("s5_x_rd_en_idle", x_rd_en, 0);
        x_fifo.delete();
        drive_fifos();

        // Random x*y with random back-pressure
        clear_stats();
        full_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] a;
            gen_val(); a = rand_val;
            gen_val();
            push_pair(a, rand_val, ref_mul(a, rand_val));
        end
        drain(2000);
        chk("rand_xy_pushes", pushes, 60);
        full_rand = 1'b0;
        z_full = 1'b0;

        // Random square mode with y empty
        clear_stats();
        square_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gen_val();
            push_pair(rand_val, '0, ref_mul(rand_val, rand_val));
        end
        drain(500);
        chk("rand_sq_pushes", pushes, 40);
        square_mode = 1'b0;

        // Reset mid-stream with 4 samples in flight
        clear_stats();
        z_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] a, b;
            a = DW'($urandom_range(0, 4095));
            b = DW'($urandom_range(0, 4095));
            push_pair(a, b, ref_mul(a, b));
        end
        n = 0;
        while (issues < 4 && n < 20) begin
            step();
            n++;
        end
        chk("s6_issues_before_reset", issues, 4);
        z_full = 1'b0;
        #1;
        chk("s6_push_before_reset", z_wr_en, 1);
        reset = 1'b0;
        #1;
        chk("s6_rst_x_rd_en", x_rd_en, 0);
        chk("s6_rst_y_rd_en", y_rd_en, 0);
        chk("s6_rst_z_wr_en", z_wr_en, 0);
        chk("s6_rst_z_din", z_din, 0);
        chk("s6_rst_busy", busy, 0);
        repeat (2) step();
        chk("s6_no_push_in_reset", pushes, 0);
        repeat (4) void'(exp_q.pop_front());
        clear_stats();
        reset = 1'b1;
        drain(50);
        chk("s6_post_latency", 64'(first_push_cyc - first_issue_cyc), PIPE + 1);
        chk("s6_post_pushes", pushes, 2);
        chk("s6_fifo_empty", 64'(x_fifo.size() + y_fifo.size()), 0);

`ifdef MULT_SATURATE_EN
        chk("sat_clear_after_reset", sat_flag, 0);
        clear_stats();
        push_pair(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        drain(50);
        chk("sat_flag_set", sat_flag, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stream_multiply.md
Name: stream_multiply

Overview:
Parametrised streaming fixed-point multiplier for the FM radio datapath. It generalises the single-input pilot squarer into a two-operand block with a runtime square mode. The block pops operands from upstream show-ahead FIFOs, multiplies them in a configurable pipeline and dequantises the result. Results pass through an internal credit-controlled output buffer into a downstream FIFO. Example uses: pilot squaring (x*x), and demodulator/mixer products (x*y).

Parameters:
DATA_SIZE, 32, signed sample width of operands and result
QUANT_BITS, 10, fractional bits; product is divided by 2^QUANT_BITS
PIPE_STAGES, 2, multiply pipeline register stages, legal 1..4
OBUF_DEPTH, 8, internal output buffer entries, power of two, must be >= PIPE_STAGES+1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
square_mode  in  1  1: z = x*x, y FIFO ignored; 0: z = x*y
x_dout  in  DATA_SIZE  head of upstream x FIFO (show-ahead, signed)
x_empty  in  1  x FIFO empty
x_rd_en  out  1  pop x FIFO
y_dout  in  DATA_SIZE  head of upstream y FIFO (show-ahead, signed)
y_empty  in  1  y FIFO empty
y_rd_en  out  1  pop y FIFO
z_din  out  DATA_SIZE  result to downstream FIFO
z_wr_en  out  1  push downstream FIFO
z_full  in  1  downstream FIFO full
busy  out  1  any sample in pipeline or output buffer

Behaviour:
- Clock is clock. Reset is reset: asynchronous, active-low.
- Reset values: x_rd_en=0, y_rd_en=0, z_wr_en=0, z_din=0, busy=0. Pipeline valid bits, buffer pointers and the in-flight counter are all 0.
- Issue condition: !x_empty && (square_mode || !y_empty) && (inflight + obuf_count) < OBUF_DEPTH.
- On issue, x_rd_en=1 (and y_rd_en=1 when square_mode=0) in that cycle. Operands are sampled from x_dout/y_dout in the same cycle. At most one issue per cycle.
- x_rd_en and y_rd_en are combinational from the issue condition. They are never asserted while the corresponding FIFO is empty. y_rd_en is never asserted in square mode.
- square_mode is sampled per issue. Changing it mid-stream affects only later issues; in-flight samples are unaffected.
- Arithmetic:
  - Full signed product is 2*DATA_SIZE bits.
  - Dequantise: divide by 2^QUANT_BITS, truncating toward zero. For a negative product, add (2^QUANT_BITS - 1) before the arithmetic right shift.
  - The low DATA_SIZE bits are taken (wrap), unless the optional feature is enabled.
- Pipeline:
  - PIPE_STAGES registered stages, each with a valid bit. Dequantise is in the last stage.
  - The pipeline never stalls; the credit check guarantees a buffer slot on exit.
  - The result enters the output buffer PIPE_STAGES cycles after issue.
- Output buffer:
  - Circular buffer, OBUF_DEPTH entries, wrap-around read and write pointers, count 0..OBUF_DEPTH.
  - Drain rule: if count>0 and !z_full, then z_wr_en=1 and z_din = head entry (registered), and pop.
  - Simultaneous buffer write and drain in one cycle: count unchanged.
- Latency: issue in cycle T gives z_wr_en in cycle T+PIPE_STAGES+1 when the buffer is empty and z_full=0. Sustained throughput is 1 sample/cycle.
- Back-pressure: with z_full held high, at most OBUF_DEPTH samples are accepted, then issue stops. No sample is lost or duplicated, and output order equals issue order.
- inflight counter: +1 on issue, -1 on pipeline exit; both in one cycle gives no change.
- busy = (inflight != 0) || (obuf_count != 0).
- Reset asserted mid-operation: all in-flight and buffered samples are discarded and outputs return to reset values immediately. Upstream FIFO contents are untouched.

Optional Feature:
- Macro: MULT_SATURATE_EN.
- Defined: after dequantise, the result clamps to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1]. Sticky output sat_flag (1 bit) is set on any clamp and cleared only by reset.
- Not defined: low-bit wrap, and no sat_flag port.

Test Plan:
Each scenario uses defaults unless stated.
1. Mode x*y: square_mode=0, x=0x400 (1.0), y=0x800 (2.0) -> z_din=0x800. z_wr_en fires exactly PIPE_STAGES+1=3 cycles after x_rd_en/y_rd_en.
2. Square mode: square_mode=1, x=0x600 (1.5), y FIFO non-empty -> z_din=0x900. y_rd_en stays 0 throughout.
3. Truncation toward zero: x=0xFFFFFFFF (-1), y=0x1 -> z=0. x=0xFFFFF800 (-2.0), y=0x600 (1.5) -> z=0xFFFFF400 (-3.0).
4. Back-pressure: 40 sequential x/y pairs, z_full held 1 for 50 cycles then 0. Issues stop after exactly 8 accepted. All 40 results then appear in order with no gaps while z_full=0. busy falls after the last push.
5. Starvation/mismatch: x has 5 samples, y has 3 (mode 0). Exactly 3 issues occur; x keeps 2 entries and x_rd_en stays 0 afterwards.
6. Reset mid-stream: reset=0 while 4 samples are in flight. Outputs clear in the same cycle, busy=0, and no z_wr_en occurs after release until a new issue. With MULT_SATURATE_EN, x=y=0x7FFFFFFF -> z=0x7FFFFFFF and sat_flag=1.
